// File: rtl/demux_struct.sv
// 1-to-4 demultiplexer with a gate-level select decoder and optional output register.
// REG_OUT = 1 gives one-cycle latency with hold on en = 0; REG_OUT = 0 is purely combinational.
module demux_struct #(
    parameter bit REG_OUT = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       d,
    input  logic [1:0] s,
    output logic [3:0] y,
    output logic       vld
);

    logic       s1_n;
    logic       s0_n;
    logic [3:0] dec;
    logic [3:0] nxt;

    not u_inv_s1 (s1_n, s[1]);
    not u_inv_s0 (s0_n, s[0]);

    and u_dec0 (dec[0], s1_n, s0_n);
    and u_dec1 (dec[1], s1_n, s[0]);
    and u_dec2 (dec[2], s[1], s0_n);
    and u_dec3 (dec[3], s[1], s[0]);

    // Each output is gated by d, so d = 0 clears every bit regardless of s.
    for (genvar k = 0; k < 4; k++) begin : g_gate
        and u_gate (nxt[k], dec[k], d);
    end

    if (REG_OUT) begin : g_reg
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                y   <= '0;
                vld <= 1'b0;
            end else begin
                vld <= en;
                if (en) begin
                    y <= nxt;
                end
            end
        end
    end else begin : g_comb
        always_comb begin
            y   = en ? nxt : '0;
            vld = en;
        end
    end

endmodule

// File: tb/tb_demux_struct.sv
// Scoreboard bench: registered and combinational demux_struct instances share one stimulus stream.
module tb_demux_struct;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       d;
    logic [1:0] s;
    logic [3:0] y_r;
    logic       vld_r;
    logic [3:0] y_c;
    logic       vld_c;

    int unsigned checks;
    int unsigned errors;

    logic [4:0] exp_q[$];
    logic [3:0] model_y;

    demux_struct #(.REG_OUT(1'b1)) dut_reg (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (en),
        .d    (d),
        .s    (s),
        .y    (y_r),
        .vld  (vld_r)
    );

    demux_struct #(.REG_OUT(1'b0)) dut_comb (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (en),
        .d    (d),
        .s    (s),
        .y    (y_c),
        .vld  (vld_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: output k carries d when s == k, as plain arithmetic.
    function automatic logic [3:0] route(input logic dv, input logic [1:0] sv);
        route = dv ? 4'(1 << sv) : 4'd0;
    endfunction

    task automatic drive(input logic en_v, input logic d_v, input logic [1:0] s_v);
        @(negedge clk);
        en = en_v;
        d  = d_v;
        s  = s_v;
        #1;
        check("comb_y",   {28'd0, y_c},   {28'd0, (en_v ? route(d_v, s_v) : 4'd0)});
        check("comb_vld", {31'd0, vld_c}, {31'd0, en_v});
        if (en_v) model_y = route(d_v, s_v);
        exp_q.push_back({model_y, en_v});
    endtask

    // Monitor: registered outputs settle just after each rising edge.
    initial begin
        logic [4:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("reg_y",   {28'd0, y_r},   {28'd0, e[4:1]});
                check("reg_vld", {31'd0, vld_r}, {31'd0, e[0]});
                check("reg_onehot", {31'd0, ($countones(y_r) <= 1)}, 32'd1);
            end
        end
    end

    initial begin
        rst_n   = 1'b0;
        en      = 1'b0;
        d       = 1'b0;
        s       = 2'd0;
        model_y = 4'd0;
        #1;
        check("rst_y",   {28'd0, y_r},   32'd0);
        check("rst_vld", {31'd0, vld_r}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 2'(i));
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 2'(i));

        drive(1'b1, 1'b1, 2'd2);
        repeat (3) drive(1'b0, 1'b1, 2'd3);

        // Asynchronous reset between edges while y holds 1000.
        drive(1'b1, 1'b1, 2'd3);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        en    = 1'b0;
        #1;
        check("async_rst_y",   {28'd0, y_r},   32'd0);
        check("async_rst_vld", {31'd0, vld_r}, 32'd0);
        check("comb_rst_y",    {28'd0, y_c},   32'd0);
        model_y = 4'd0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 1'b1, 2'd1);

        for (int i = 0; i < 1000; i++) begin
            drive(($urandom_range(3, 0) != 0), 1'($urandom), 2'($urandom));
        end

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        check("queue_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
